// File: rtl/wb_ext_responder.sv
// wb_ext_responder
// Wishbone B3 responder that terminates a compute tile's external bus with a
// word-addressed on-chip memory. It handles classic cycles and
// registered-feedback incrementing bursts (linear and wrap-4/8/16). Every
// cycle or burst waits WAIT_CYCLES before its first acknowledge. Addresses
// outside the memory window get a single-cycle error.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active low
//   wb_ext_adr_i   byte address (bits [1:0] ignored)
//   wb_ext_cyc_i   cycle valid
//   wb_ext_stb_i   strobe
//   wb_ext_we_i    write enable
//   wb_ext_sel_i   byte lane select
//   wb_ext_dat_i   write data
//   wb_ext_cab_i   ignored
//   wb_ext_cti_i   cycle type (010 incrementing burst, anything else ends)
//   wb_ext_bte_i   burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wb_ext_ack_o   acknowledge
//   wb_ext_err_o   error (out-of-range address)
//   wb_ext_rty_o   retry, never asserted
//   wb_ext_dat_o   read data, zero when not acknowledging
//
// MEM_AW is expected to lie between 4 and 29, so that wrap-16 fits inside
// the memory and the byte window fits inside 32 bits.

module wb_ext_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_ext_adr_i,
  input  logic        wb_ext_cyc_i,
  input  logic        wb_ext_stb_i,
  input  logic        wb_ext_we_i,
  input  logic [3:0]  wb_ext_sel_i,
  input  logic [31:0] wb_ext_dat_i,
  input  logic        wb_ext_cab_i,
  input  logic [2:0]  wb_ext_cti_i,
  input  logic [1:0]  wb_ext_bte_i,
  output logic        wb_ext_ack_o,
  output logic        wb_ext_err_o,
  output logic        wb_ext_rty_o,
  output logic [31:0] wb_ext_dat_o
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_BURST
  } state_e;

  state_e            state_q;
  logic              ack_q;
  logic              err_q;
  logic              inr_q;
  logic [3:0]        wcnt_q;
  logic [MEM_AW-1:0] beat_addr_q;
  logic [MEM_AW-1:0] beat_addr_d;
  logic [31:0]       mem_q [DEPTH];

  logic              req;
  logic              cti_incr;
  logic [31:0]       offset;
  logic              in_range;
  logic [MEM_AW-1:0] index;
  logic [MEM_AW-1:0] wrap_mask;
  logic [MEM_AW-1:0] beat_inc;
  logic              unused_bits;

  assign req      = wb_ext_cyc_i & wb_ext_stb_i;
  assign cti_incr = (wb_ext_cti_i == 3'b010);

  // The offset from the base decides both the word index and the range
  // check. An address below the base wraps to a huge offset, but the
  // explicit compare keeps that case out of range too.
  assign offset   = wb_ext_adr_i - BASE_ADDR;
  assign in_range = (wb_ext_adr_i >= BASE_ADDR) && (offset[31:MEM_AW+2] == '0);
  assign index    = offset[MEM_AW+1:2];

  assign unused_bits = ^{wb_ext_cab_i, offset[1:0]};

  // Wrap bursts only move the low log2(N) bits of the beat address, and the
  // upper bits hold. A linear burst uses an all-ones mask, so it rolls over
  // at the top of memory.
  always_comb begin
    wrap_mask = '1;
    case (wb_ext_bte_i)
      2'b01:   wrap_mask = MEM_AW'(3);
      2'b10:   wrap_mask = MEM_AW'(7);
      2'b11:   wrap_mask = MEM_AW'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign beat_inc    = beat_addr_q + MEM_AW'(1);
  assign beat_addr_d = (beat_addr_q & ~wrap_mask) | (beat_inc & wrap_mask);

  // ack_q means "ready to acknowledge". The visible ack is gated by the
  // current request, so a stalled burst beat (stb low) shows no ack and is
  // not consumed.
  assign wb_ext_ack_o = ack_q & req;
  assign wb_ext_err_o = err_q;
  assign wb_ext_rty_o = 1'b0;
  assign wb_ext_dat_o = wb_ext_ack_o ? mem_q[beat_addr_q] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      inr_q       <= 1'b0;
      wcnt_q      <= '0;
      beat_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            beat_addr_q <= index;
            inr_q       <= in_range;
            wcnt_q      <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ack_q   <= in_range;
              err_q   <= !in_range;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (!req) begin
            state_q <= ST_IDLE;
          end else if (wcnt_q == 4'd1) begin
            state_q <= ST_RESP;
            ack_q   <= inr_q;
            err_q   <= !inr_q;
          end
        end
        ST_RESP: begin
          err_q <= 1'b0;
          // Out-of-range cycles have inr_q low, so they never reach BURST.
          if (req && inr_q && cti_incr) begin
            state_q     <= ST_BURST;
            ack_q       <= 1'b1;
            beat_addr_q <= beat_addr_d;
          end else begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
        ST_BURST: begin
          if (!wb_ext_cyc_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end else if (req) begin
            if (cti_incr) begin
              beat_addr_q <= beat_addr_d;
            end else begin
              state_q <= ST_IDLE;
              ack_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Memory contents survive reset. A write needs a visible ack, and reset
  // clears ack_q at once, so a reset edge never commits a beat.
  always_ff @(posedge clk) begin
    if (wb_ext_ack_o && wb_ext_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_ext_sel_i[b]) begin
          mem_q[beat_addr_q][8*b +: 8] <= wb_ext_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ext_responder.sv
// tb_wb_ext_responder
// Two responders share clock and reset. dut0 has no wait states and dut3
// has three. A word-level model of dut0's memory, written with plain byte
// merges and burst address arithmetic, supplies every expected value.

module tb_wb_ext_responder;

  localparam int          MEM_AW = 10;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] BASE   = 32'h0000_4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr  [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic        cab  [2];
  logic [2:0]  cti  [2];
  logic [1:0]  bte  [2];
  logic        ack  [2];
  logic        err  [2];
  logic        rty  [2];
  logic [31:0] rdat [2];

  wb_ext_responder #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .wb_ext_adr_i(adr[0]), .wb_ext_cyc_i(cyc[0]), .wb_ext_stb_i(stb[0]),
    .wb_ext_we_i(we[0]), .wb_ext_sel_i(sel[0]), .wb_ext_dat_i(wdat[0]),
    .wb_ext_cab_i(cab[0]), .wb_ext_cti_i(cti[0]), .wb_ext_bte_i(bte[0]),
    .wb_ext_ack_o(ack[0]), .wb_ext_err_o(err[0]), .wb_ext_rty_o(rty[0]),
    .wb_ext_dat_o(rdat[0])
  );

  wb_ext_responder #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .wb_ext_adr_i(adr[1]), .wb_ext_cyc_i(cyc[1]), .wb_ext_stb_i(stb[1]),
    .wb_ext_we_i(we[1]), .wb_ext_sel_i(sel[1]), .wb_ext_dat_i(wdat[1]),
    .wb_ext_cab_i(cab[1]), .wb_ext_cti_i(cti[1]), .wb_ext_bte_i(bte[1]),
    .wb_ext_ack_o(ack[1]), .wb_ext_err_o(err[1]), .wb_ext_rty_o(rty[1]),
    .wb_ext_dat_o(rdat[1])
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] model [DEPTH];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Word touched by beat k of a burst: wrap-N stays in the aligned N-word
  // block, and linear rolls over at the end of memory.
  function automatic int burst_word(input int start, input logic [1:0] b, input int k);
    int n;
    n = (b == 2'b00) ? DEPTH : (2 << b);
    return ((start / n) * n + (start + k) % n) % DEPTH;
  endfunction

  task automatic bus_idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0;
    wdat[d] = '0; cab[d] = 1'b0; cti[d] = '0; bte[d] = '0;
  endtask

  // Classic master. n is the cycle (after the request is first sampled)
  // that shows ack or err, or -1 if neither shows. tail is ack|err in the
  // cycle after termination, with a fresh read request held.
  task automatic classic(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] dv, output int n, output logic [31:0] rd,
                         output bit got_ack, output bit got_err, output bit tail);
    n = -1; rd = '0; got_ack = 1'b0; got_err = 1'b0; tail = 1'b0;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = dv;
    cti[d] = 3'b000; bte[d] = 2'b00;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ack[d] || err[d]) begin
        n = c; got_ack = ack[d]; got_err = err[d]; rd = rdat[d];
        break;
      end
    end
    @(posedge clk); #1; we[d] = 1'b0; sel[d] = '0;
    @(negedge clk); tail = ack[d] | err[d];
    @(posedge clk); #1; bus_idle(d);
    @(posedge clk); #1;
  endtask

  task automatic preload(input int word, input logic [31:0] v);
    int n; logic [31:0] rd; bit a, e, t;
    classic(0, 1'b1, BASE + 32'(word) * 4, 4'hF, v, n, rd, a, e, t);
    model[word] = v;
  endtask

  // Burst master on dut0. The address stays at the start word, because the
  // responder owns the beat address. gap_len idle-strobe cycles follow the
  // beat that makes beats == gap_after.
  task automatic burst(input bit w, input int start, input logic [1:0] b, input int nbeats,
                       input int gap_after, input int gap_len, input logic [31:0] wd[16],
                       output logic [31:0] rd[16], output int ack_cyc[16],
                       output int beats, output int gap_acks, output bit tail);
    int gap_left;
    beats = 0; gap_acks = 0; gap_left = 0; tail = 1'b0;
    for (int k = 0; k < 16; k++) begin rd[k] = '0; ack_cyc[k] = -1; end
    for (int c = 0; c < 60 && beats < nbeats; c++) begin
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = (gap_left == 0); we[0] = w; sel[0] = 4'hF;
      adr[0] = BASE + 32'(start) * 4; bte[0] = b; wdat[0] = wd[beats];
      cti[0] = (beats == nbeats - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      if (stb[0]) begin
        if (ack[0]) begin
          rd[beats] = rdat[0]; ack_cyc[beats] = c; beats++;
          if (beats == gap_after) gap_left = gap_len;
        end
      end else begin
        if (ack[0]) gap_acks++;
        gap_left--;
      end
    end
    @(posedge clk); #1; stb[0] = 1'b1; cti[0] = 3'b000; we[0] = 1'b0; sel[0] = '0;
    @(negedge clk); tail = ack[0] | err[0];
    @(posedge clk); #1; bus_idle(0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus_idle(0); bus_idle(1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests_run++; if ({ack[d], err[d], rty[d]} !== 3'b000) begin tests_failed++;
        $display("[TB] FAIL reset_flags dut%0d: got %b, expected 000", d, {ack[d], err[d], rty[d]}); end
      tests_run++; if (rdat[d] !== 32'h0) begin tests_failed++;
        $display("[TB] FAIL reset_dat dut%0d: got %h, expected 0", d, rdat[d]); end
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_classic();
    int n; logic [31:0] rd; bit a, e, t;
    classic(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, n, rd, a, e, t);
    model[4] = 32'hDEADBEEF;
    tests_run++; if (n !== 1 || a !== 1'b1 || e !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL classic_write: got n=%0d ack=%b err=%b, expected n=1 ack=1 err=0", n, a, e); end
    tests_run++; if (t !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL classic_write_tail: got %b, expected 0", t); end
    classic(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (n !== 1 || a !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL classic_read_lat: got n=%0d ack=%b, expected n=1 ack=1", n, a); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++;
      $display("[TB] FAIL classic_read_data: got %h, expected deadbeef", rd); end
  endtask

  task automatic test_partial();
    int n; logic [31:0] rd, v, pd; logic [3:0] s; bit a, e, t; int w;
    preload(9, 32'h11223344);
    classic(0, 1'b1, BASE + 32'd36, 4'b0010, 32'h0000AB00, n, rd, a, e, t);
    model[9] = merge(model[9], 32'h0000AB00, 4'b0010);
    classic(0, 1'b0, BASE + 32'd36, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (rd !== 32'h1122AB44) begin tests_failed++;
      $display("[TB] FAIL partial_fixed: got %h, expected 1122ab44", rd); end
    for (int i = 0; i < 6; i++) begin
      w = 32 + int'($urandom_range(0, 31)); v = $urandom; pd = $urandom;
      s = 4'($urandom_range(0, 15));
      preload(w, v);
      classic(0, 1'b1, BASE + 32'(w) * 4, s, pd, n, rd, a, e, t);
      model[w] = merge(model[w], pd, s);
      classic(0, 1'b0, BASE + 32'(w) * 4, 4'hF, 32'h0, n, rd, a, e, t);
      tests_run++; if (rd !== model[w]) begin tests_failed++;
        $display("[TB] FAIL partial_rand word %0d sel %b: got %h, expected %h", w, s, rd, model[w]); end
    end
  endtask

  task automatic test_wait_states();
    int n, first; logic [31:0] rd, v; bit a, e, t;
    v = $urandom;
    classic(1, 1'b1, BASE + 32'h10, 4'hF, v, n, rd, a, e, t);
    tests_run++; if (n !== 4 || a !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL wait_write_lat: got n=%0d ack=%b, expected n=4 ack=1", n, a); end
    classic(1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (n !== 4 || rd !== v) begin tests_failed++;
      $display("[TB] FAIL wait_read: got n=%0d data=%h, expected n=4 data=%h", n, rd, v); end
    // Strobe drops in cycle 2 and returns in cycle 3, so the restarted
    // cycle must pay the full wait again: its ack lands in cycle 7.
    first = -1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF;
        adr[1] = BASE + 32'h10; cti[1] = 3'b000; bte[1] = 2'b00;
      end
      if (c == 2) stb[1] = 1'b0;
      if (c == 3) stb[1] = 1'b1;
      @(negedge clk);
      if (ack[1]) begin first = c; rd = rdat[1]; break; end
    end
    @(posedge clk); #1; bus_idle(1);
    @(posedge clk); #1;
    tests_run++; if (first !== 7) begin tests_failed++;
      $display("[TB] FAIL wait_abort_restart: got first ack cycle %0d, expected 7", first); end
    tests_run++; if (rd !== v) begin tests_failed++;
      $display("[TB] FAIL wait_abort_data: got %h, expected %h", rd, v); end
  endtask

  task automatic check_burst_read(input string name, input int start, input logic [1:0] b,
                                  input int nb);
    logic [31:0] wd[16], rd[16]; int ac[16]; int beats, gaps; bit t; int w;
    for (int k = 0; k < 16; k++) wd[k] = '0;
    burst(1'b0, start, b, nb, -1, 0, wd, rd, ac, beats, gaps, t);
    tests_run++; if (beats !== nb) begin tests_failed++;
      $display("[TB] FAIL %s_beats: got %0d, expected %0d", name, beats, nb); end
    for (int k = 0; k < nb; k++) begin
      w = burst_word(start, b, k);
      tests_run++; if (rd[k] !== model[w] || ac[k] !== k + 1) begin tests_failed++;
        $display("[TB] FAIL %s beat %0d: got %h at cycle %0d, expected %h (word %0d) at cycle %0d",
                 name, k, rd[k], ac[k], model[w], w, k + 1); end
    end
    tests_run++; if (t !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL %s_after_end: got ack/err %b, expected 0", name, t); end
  endtask

  task automatic test_wrap_burst();
    int blk, start;
    for (int w = 4; w < 8; w++) preload(w, $urandom);
    check_burst_read("wrap4", 6, 2'b01, 4);
    blk = 64 + int'($urandom_range(0, 63));
    for (int w = 0; w < 8; w++) preload(blk * 8 + w, $urandom);
    start = blk * 8 + int'($urandom_range(0, 7));
    check_burst_read("wrap8", start, 2'b10, 8);
  endtask

  task automatic test_linear_wrap();
    preload(1022, $urandom); preload(1023, $urandom); preload(0, $urandom); preload(1, $urandom);
    check_burst_read("linear_rollover", 1022, 2'b00, 4);
  endtask

  task automatic test_linear_gap_write();
    logic [31:0] wd[16], rd[16]; int ac[16]; int beats, gaps, n, w0; bit t, a, e;
    logic [31:0] r;
    w0 = 100 + int'($urandom_range(0, 99));
    for (int k = 0; k < 16; k++) wd[k] = $urandom;
    burst(1'b1, w0, 2'b00, 4, 2, 2, wd, rd, ac, beats, gaps, t);
    for (int k = 0; k < 4; k++) model[w0 + k] = wd[k];
    tests_run++; if (beats !== 4 || gaps !== 0) begin tests_failed++;
      $display("[TB] FAIL gap_write_acks: got beats=%0d gap_acks=%0d, expected 4 and 0", beats, gaps); end
    tests_run++; if (ac[0] !== 1 || ac[1] !== 2 || ac[2] !== 5 || ac[3] !== 6) begin tests_failed++;
      $display("[TB] FAIL gap_write_timing: got %0d %0d %0d %0d, expected 1 2 5 6",
               ac[0], ac[1], ac[2], ac[3]); end
    for (int k = 0; k < 4; k++) begin
      classic(0, 1'b0, BASE + 32'(w0 + k) * 4, 4'hF, 32'h0, n, r, a, e, t);
      tests_run++; if (r !== model[w0 + k]) begin tests_failed++;
        $display("[TB] FAIL gap_write_word %0d: got %h, expected %h", w0 + k, r, model[w0 + k]); end
    end
  endtask

  task automatic test_out_of_range();
    int n; logic [31:0] rd; bit a, e, t;
    classic(0, 1'b0, BASE + 32'(DEPTH) * 4, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (n !== 1 || e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin tests_failed++;
      $display("[TB] FAIL oor_read: got n=%0d err=%b ack=%b dat=%h, expected 1 1 0 0", n, e, a, rd); end
    tests_run++; if (t !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL oor_err_pulse: got %b next cycle, expected 0", t); end
    classic(0, 1'b1, BASE + 32'(DEPTH) * 4 + 32'h10, 4'hF, 32'h5A5A5A5A, n, rd, a, e, t);
    tests_run++; if (e !== 1'b1 || a !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL oor_write: got err=%b ack=%b, expected 1 0", e, a); end
    classic(0, 1'b0, BASE - 32'd4, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (e !== 1'b1 || a !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL below_base: got err=%b ack=%b, expected 1 0", e, a); end
    classic(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, a, e, t);
    tests_run++; if (rd !== model[4]) begin tests_failed++;
      $display("[TB] FAIL oor_no_alias: got %h, expected %h", rd, model[4]); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] nd[8]; logic [31:0] r; int w0, beats, n; bit a, e, t;
    w0 = 300 + int'($urandom_range(0, 400));
    for (int k = 0; k < 8; k++) begin preload(w0 + k, $urandom); nd[k] = $urandom; end
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = BASE + 32'(w0) * 4;
      cti[0] = 3'b010; bte[0] = 2'b00; wdat[0] = nd[beats];
      @(negedge clk);
      if (ack[0]) begin
        if (beats == 3) break;
        beats++;
      end
    end
    tests_run++; if (beats !== 3 || ack[0] !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL rst_burst_setup: got beats=%0d ack=%b, expected 3 1", beats, ack[0]); end
    rst = 1'b0;
    #1;
    tests_run++; if ({ack[0], err[0], rty[0]} !== 3'b000 || rdat[0] !== 32'h0) begin tests_failed++;
      $display("[TB] FAIL rst_immediate: got flags=%b dat=%h, expected 000 0",
               {ack[0], err[0], rty[0]}, rdat[0]); end
    for (int k = 0; k < 3; k++) model[w0 + k] = nd[k];
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (ack[0] !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL rst_held: got ack %b, expected 0", ack[0]); end
    @(posedge clk); #1; bus_idle(0); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      classic(0, 1'b0, BASE + 32'(w0 + k) * 4, 4'hF, 32'h0, n, r, a, e, t);
      tests_run++; if (r !== model[w0 + k]) begin tests_failed++;
        $display("[TB] FAIL rst_mem word %0d: got %h, expected %h", w0 + k, r, model[w0 + k]); end
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_partial();
    test_wait_states();
    test_wrap_burst();
    test_linear_wrap();
    test_linear_gap_write();
    test_out_of_range();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_ext_responder.md
Name: wb_ext_responder

Overview:
- Wishbone B3 slave (responder) that terminates one tile's external bus (the wb_ext_* group driven by a compute tile) with a word-addressed on-chip memory.
- Supports classic cycles and registered-feedback incrementing bursts (linear and wrap-4/8/16).
- Supports programmable wait states and error response on out-of-range addresses.
- Instantiated once per tile in system top levels and benches, in place of an external memory.

Parameters:
- MEM_AW, 10, word-address width; memory holds 2**MEM_AW 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to the memory size.
- WAIT_CYCLES, 0, wait states (0..15) before the first ack of every cycle or burst.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- wb_ext_adr_i  in  32  byte address; bits [1:0] ignored
- wb_ext_cyc_i  in  1  cycle valid
- wb_ext_stb_i  in  1  strobe
- wb_ext_we_i  in  1  write enable
- wb_ext_sel_i  in  4  byte lane select; bit n selects byte [8n+7:8n]
- wb_ext_dat_i  in  32  write data
- wb_ext_cab_i  in  1  ignored
- wb_ext_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other values are treated as 000
- wb_ext_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_ext_ack_o  out  1  acknowledge
- wb_ext_err_o  out  1  error
- wb_ext_rty_o  out  1  retry; tied to 0
- wb_ext_dat_o  out  32  read data

Behaviour:
- Reset (rst==0, async):
  - State returns to IDLE; ack_o, err_o, rty_o and dat_o go to 0; wait counter and beat address clear.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it with no further ack, and no write occurs on the reset edge.
- Request: req = cyc_i & stb_i. Index = (adr_i - BASE_ADDR) >> 2. in_range = adr_i >= BASE_ADDR and index < 2**MEM_AW.
- States:
  - IDLE: if req, latch beat_addr = index[MEM_AW-1:0] and load wcnt = WAIT_CYCLES.
    - If WAIT_CYCLES == 0, go to RESP.
    - Otherwise go to WAIT.
  - WAIT: decrement wcnt each cycle. When wcnt == 1, go to RESP. If req drops, return to IDLE (abort, no ack).
  - RESP: ack_o = in_range, or err_o = !in_range, asserted for this cycle (registered outputs).
    - Next state is BURST if cti_i == 010, in_range and req. Otherwise IDLE.
  - BURST: ack_o stays high on every cycle with req, one beat per cycle, with no wait states after the first beat.
    - beat_addr advances after each acked beat. Linear: +1, wrapping modulo memory size. Wrap-N: the low log2(N) bits increment modulo N and the upper bits hold.
    - If stb_i drops with cyc_i high: ack_o deasserts, beat_addr holds, and the state stays in BURST.
    - Leave to IDLE on the edge that acks a beat with cti_i == 111 or 000, or when cyc_i drops.
- Latency: first ack_o/err_o is high in cycle WAIT_CYCLES+1 after req is first sampled. Classic back-to-back transfers therefore take at least 2 cycles each (IDLE gap).
- Data:
  - Reads: dat_o = mem[beat_addr] while ack_o; 0 otherwise.
  - Writes: on a clock edge with ack_o & req & we_i, bytes of mem[beat_addr] selected by sel_i take dat_i. sel_i == 0 acks with no write.
- Errors: an out-of-range access never writes and never starts a burst. err_o is a single-cycle pulse. ack_o and err_o are never high together.
- The master changing adr_i mid-burst is ignored; beat_addr is authoritative.

Test Plan:
- WAIT_CYCLES=0: classic write 0xDEADBEEF to BASE+0x10 with sel=1111, then classic read of the same address -> ack in 1st cycle after stb each time; read returns 0xDEADBEEF.
- Partial write: sel=0010 with dat 0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
- WAIT_CYCLES=3: classic read -> ack high exactly in the 4th cycle after stb is sampled; dropping stb in cycle 2 -> no ack, FSM returns to IDLE.
- Wrap4 burst read starting at word 6, cti 010,010,010,111 -> acks on 4 consecutive cycles, data from words 6,7,4,5; ack low on the following cycle.
- Linear burst write of 4 beats with stb dropped for 2 cycles after beat 2 -> ack low during the gap; words N..N+3 written correctly.
- Read at BASE+(2**MEM_AW)*4 -> single-cycle err_o, ack_o=0, memory unchanged. Assert rst low mid-burst -> all outputs 0 immediately.
